// File: rtl/pixel_mem_arbiter.sv
// Arbitrates one single-port pixel buffer between VGA scan-out reads (priority)
// and queued processor writebacks, with a starvation guard for the write path.
module pixel_mem_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_STARVE = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              cpu_wr_valid,
    output logic              cpu_wr_ready,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        fifo_level
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = (MAX_STARVE > 1) ? $clog2(MAX_STARVE) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(MAX_STARVE - 1);
    localparam logic [2:0] LevelFull = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StVga, StCpu} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [2:0]        level_q, level_d;
    logic [CntW-1:0]   starve_q, starve_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] vga_hold_q;
    logic              vga_valid_q, vga_miss_q;
    logic              push, pop, fifo_ne, force_cpu;

    assign fifo_ne      = (level_q != 3'd0);
    assign force_cpu    = (starve_q == StarveMax) && fifo_ne;
    assign cpu_wr_ready = (level_q < LevelFull);
    assign push         = cpu_wr_valid && cpu_wr_ready;

    always_comb begin
        state_d  = StIdle;
        pop      = 1'b0;
        starve_d = starve_q;
        level_d  = level_q;
        if (vga_req && !force_cpu) begin
            state_d = StVga;
        end else if (fifo_ne) begin
            state_d = StCpu;
            pop     = 1'b1;
        end
        if (!fifo_ne || state_d == StCpu) begin
            starve_d = '0;
        end else if (state_d == StVga && starve_q != StarveMax) begin
            starve_d = starve_q + CntW'(1);
        end
        level_d = level_q + 3'(push) - 3'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vga_hold_q  <= '0;
            vga_valid_q <= 1'b0;
            vga_miss_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            starve_q   <= starve_d;
            vga_miss_q <= vga_req && force_cpu;
            // RAM returns data the cycle after a read access is presented.
            vga_valid_q <= (state_q == StVga);
            if (vga_valid_q) vga_hold_q <= mem_rdata;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case (state_d)
                StVga: mem_addr_q <= vga_addr;
                StCpu: begin
                    mem_addr_q  <= fifo_addr[rd_ptr_q];
                    mem_wdata_q <= fifo_data[rd_ptr_q];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= cpu_wr_addr;
            fifo_data[wr_ptr_q] <= cpu_wr_data;
        end
    end

    assign mem_en     = (state_q != StIdle);
    assign mem_we     = (state_q == StCpu);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign vga_valid  = vga_valid_q;
    assign vga_data   = vga_valid_q ? mem_rdata : vga_hold_q;
    assign vga_miss   = vga_miss_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Scoreboard bench for pixel_mem_arbiter with a behavioural 4096x12 RAM model.
module tb_pixel_mem_arbiter;

    typedef struct packed {
        logic [11:0] a;
        logic [11:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst, vga_req, vga_valid, vga_miss;
    logic        cpu_wr_valid, cpu_wr_ready, mem_en, mem_we;
    logic [11:0] vga_addr, vga_data, cpu_wr_addr, cpu_wr_data;
    logic [11:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  fifo_level;

    logic [11:0] ram [4096];
    wr_t         exp_wr_q[$], act_wr_q[$];
    logic [11:0] exp_rd_q[$], act_rd_q[$], rd_addr_q[$];
    int          wr_cyc_q[$];
    int          miss_cnt, req_cnt, cyc;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    pixel_mem_arbiter dut (
        .clk(clk), .rst(rst), .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_data(vga_data), .vga_valid(vga_valid), .vga_miss(vga_miss),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fifo_level(fifo_level)
    );

    function automatic logic [11:0] ram_init(input logic [11:0] a);
        return (a == 12'h010) ? 12'hABC : (a ^ 12'h5A5);
    endfunction

    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
        if (vga_req === 1'b1 && rst === 1'b0) req_cnt <= req_cnt + 1;
    end

    // Collects DUT activity; tasks compare it against the expected queues.
    always @(negedge clk) begin
        wr_t w;
        cyc <= cyc + 1;
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            w = wr_t'({mem_addr, mem_wdata});
            act_wr_q.push_back(w);
            wr_cyc_q.push_back(cyc);
        end
        if (mem_en === 1'b1 && mem_we === 1'b0) rd_addr_q.push_back(mem_addr);
        if (vga_valid === 1'b1) act_rd_q.push_back(vga_data);
        if (vga_miss === 1'b1) miss_cnt <= miss_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        exp_wr_q.delete(); act_wr_q.delete(); exp_rd_q.delete();
        act_rd_q.delete(); rd_addr_q.delete(); wr_cyc_q.delete();
        miss_cnt = 0;
        req_cnt  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; vga_req = 1'b0; cpu_wr_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        clear_mon();
    endtask

    // Offers one write and returns once it has been accepted (or the bound expired).
    task automatic drive_write(input logic [11:0] a, input logic [11:0] d, output bit ok);
        int n = 0;
        ok = 1'b0;
        cpu_wr_valid = 1'b1; cpu_wr_addr = a; cpu_wr_data = d;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (cpu_wr_ready) begin
                exp_wr_q.push_back(wr_t'({a, d}));
                ok = 1'b1;
            end
            tick();
            n++;
        end
        cpu_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; vga_req = 1'b0; cpu_wr_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cpu_wr_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem got en=%b we=%b want 0 0", mem_en, mem_we); end
        checks++; if (vga_valid !== 1'b0 || vga_miss !== 1'b0) begin errors++; $display("FAIL reset_vga got valid=%b miss=%b want 0 0", vga_valid, vga_miss); end
        checks++; if (vga_data !== 12'h000 || mem_addr !== 12'h000) begin errors++; $display("FAIL reset_data got vga_data=%h mem_addr=%h want 0 0", vga_data, mem_addr); end
        tick();
    endtask

    task automatic test_cpu_write();
        bit  ok;
        int  n = 0;
        wr_t e, g;
        do_reset();
        drive_write(12'h005, 12'hF00, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_accept got timeout want accepted"); end
        while (act_wr_q.size() == 0 && n < 10) begin @(negedge clk); n++; end
        checks++; if (act_wr_q.size() != 1) begin errors++; $display("FAIL wr_count got %0d want 1", act_wr_q.size()); end
        if (act_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); g = act_wr_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL wr_data got %h/%h want %h/%h", g.a, g.d, e.a, e.d); end
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL wr_level got %0d want 0", fifo_level); end
        tick();
    endtask

    task automatic test_vga_read();
        do_reset();
        vga_addr = 12'h010; vga_req = 1'b1;
        tick();
        vga_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin errors++; $display("FAIL rd_issue got en=%b we=%b addr=%h want 1 0 010", mem_en, mem_we, mem_addr); end
        checks++; if (vga_valid !== 1'b0) begin errors++; $display("FAIL rd_early got valid=%b want 0", vga_valid); end
        @(negedge clk);
        checks++; if (vga_valid !== 1'b1 || vga_data !== 12'hABC) begin errors++; $display("FAIL rd_return got valid=%b data=%h want 1 abc", vga_valid, vga_data); end
        @(negedge clk);
        checks++; if (vga_valid !== 1'b0 || vga_data !== 12'hABC) begin errors++; $display("FAIL rd_hold got valid=%b data=%h want 0 abc", vga_valid, vga_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          n = 0;
        logic [11:0] d;
        logic [11:0] d3 = 12'h000;
        wr_t         e, g;
        logic [11:0] er, gr;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            d = 12'($urandom);
            if (i == 3) d3 = d;
            drive_write(12'h200 + 12'(i), d, ok);
            checks++; if (!ok) begin errors++; $display("FAIL b2b_accept%0d got timeout want accepted", i); end
        end
        while (act_wr_q.size() < 6 && n < 20) begin @(negedge clk); n++; end
        checks++; if (act_wr_q.size() != 6) begin errors++; $display("FAIL b2b_wr_count got %0d want 6", act_wr_q.size()); end
        while (act_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); g = act_wr_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_wr got %h/%h want %h/%h", g.a, g.d, e.a, e.d); end
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            vga_addr = 12'h100 + 12'(i); vga_req = 1'b1;
            exp_rd_q.push_back(ram_init(vga_addr));
            tick();
        end
        vga_addr = 12'h203; vga_req = 1'b1;
        exp_rd_q.push_back(d3);
        tick();
        vga_req = 1'b0;
        n = 0;
        while (act_rd_q.size() < 9 && n < 10) begin @(negedge clk); n++; end
        checks++; if (act_rd_q.size() != 9) begin errors++; $display("FAIL b2b_rd_count got %0d want 9", act_rd_q.size()); end
        while (act_rd_q.size() > 0 && exp_rd_q.size() > 0) begin
            er = exp_rd_q.pop_front(); gr = act_rd_q.pop_front();
            checks++; if (gr !== er) begin errors++; $display("FAIL b2b_rd got %h want %h", gr, er); end
        end
        tick();
    endtask

    task automatic test_starvation();
        bit  ok;
        int  n = 0;
        wr_t e, g;
        do_reset();
        vga_addr = 12'h020; vga_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_write(12'h400 + 12'(i), 12'($urandom), ok);
            checks++; if (!ok) begin errors++; $display("FAIL stv_accept%0d got timeout want accepted", i); end
        end
        @(negedge clk);
        checks++; if (fifo_level !== 3'd4 || cpu_wr_ready !== 1'b0) begin errors++; $display("FAIL stv_full got level=%0d ready=%b want 4 0", fifo_level, cpu_wr_ready); end
        tick();
        drive_write(12'h404, 12'($urandom), ok);
        checks++; if (!ok) begin errors++; $display("FAIL stv_accept4 got timeout want accepted"); end
        while (act_wr_q.size() < 5 && n < 400) begin @(negedge clk); n++; end
        tick();
        vga_req = 1'b0;
        repeat (3) tick();
        checks++; if (act_wr_q.size() != 5) begin errors++; $display("FAIL stv_wr_count got %0d want 5", act_wr_q.size()); end
        for (int i = 1; i < wr_cyc_q.size(); i++) begin
            checks++; if (wr_cyc_q[i] - wr_cyc_q[i-1] != 64) begin errors++; $display("FAIL stv_period got %0d want 64", wr_cyc_q[i] - wr_cyc_q[i-1]); end
        end
        checks++; if (miss_cnt != 5) begin errors++; $display("FAIL stv_miss got %0d want 5", miss_cnt); end
        checks++; if (rd_addr_q.size() + miss_cnt != req_cnt) begin errors++; $display("FAIL stv_req_acct got %0d want %0d", rd_addr_q.size() + miss_cnt, req_cnt); end
        checks++; if (act_rd_q.size() != rd_addr_q.size()) begin errors++; $display("FAIL stv_rd_returns got %0d want %0d", act_rd_q.size(), rd_addr_q.size()); end
        foreach (act_rd_q[i]) begin
            if (act_rd_q[i] !== ram_init(12'h020) || rd_addr_q[i] !== 12'h020) begin
                checks++; errors++;
                $display("FAIL stv_rd got data=%h addr=%h want %h 020", act_rd_q[i], rd_addr_q[i], ram_init(12'h020));
                break;
            end
        end
        while (act_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); g = act_wr_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL stv_order got %h/%h want %h/%h", g.a, g.d, e.a, e.d); end
        end
    endtask

    task automatic test_full_fifo();
        bit          ok;
        int          n = 0;
        logic [11:0] d;
        wr_t         e, g;
        do_reset();
        vga_addr = 12'h030; vga_req = 1'b1;
        for (int i = 0; i < 4; i++) drive_write(12'h300 + 12'(i), 12'($urandom), ok);
        @(negedge clk);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", fifo_level); end
        tick();
        // Pop while full: the offered write must wait for the freed slot.
        d = 12'($urandom);
        vga_req = 1'b0; cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h304; cpu_wr_data = d;
        @(negedge clk);
        checks++; if (cpu_wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", cpu_wr_ready); end
        tick();
        @(negedge clk);
        checks++; if (fifo_level !== 3'd3 || cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL full_pop got level=%0d ready=%b want 3 1", fifo_level, cpu_wr_ready); end
        exp_wr_q.push_back(wr_t'({12'h304, d}));
        tick();
        d = 12'($urandom);
        cpu_wr_addr = 12'h305; cpu_wr_data = d; vga_req = 1'b1;
        @(negedge clk);
        checks++; if (fifo_level !== 3'd3 || cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop got level=%0d ready=%b want 3 1", fifo_level, cpu_wr_ready); end
        exp_wr_q.push_back(wr_t'({12'h305, d}));
        tick();
        cpu_wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_refill got %0d want 4", fifo_level); end
        tick();
        vga_req = 1'b0;
        while (act_wr_q.size() < 6 && n < 20) begin @(negedge clk); n++; end
        checks++; if (act_wr_q.size() != 6) begin errors++; $display("FAIL full_wr_count got %0d want 6", act_wr_q.size()); end
        while (act_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); g = act_wr_q.pop_front();
            checks++; if (g !== e) begin errors++; $display("FAIL full_order got %h/%h want %h/%h", g.a, g.d, e.a, e.d); end
        end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL full_drain got %0d want 0", fifo_level); end
        tick();
    endtask

    task automatic test_reset_inflight();
        bit ok;
        do_reset();
        vga_addr = 12'h040; vga_req = 1'b1;
        for (int i = 0; i < 3; i++) drive_write(12'h500 + 12'(i), 12'($urandom), ok);
        checks++; if (fifo_level !== 3'd3 || mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rstf_setup got level=%0d en=%b we=%b want 3 1 0", fifo_level, mem_en, mem_we); end
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (fifo_level !== 3'd0 || cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL rstf_level got level=%0d ready=%b want 0 1", fifo_level, cpu_wr_ready); end
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || vga_valid !== 1'b0) begin errors++; $display("FAIL rstf_outs got en=%b we=%b valid=%b want 0 0 0", mem_en, mem_we, vga_valid); end
        tick();
        rst = 1'b0; vga_req = 1'b0;
        clear_mon();
        repeat (6) tick();
        checks++; if (act_wr_q.size() != 0 || act_rd_q.size() != 0 || miss_cnt != 0) begin errors++; $display("FAIL rstf_quiet got wr=%0d rd=%0d miss=%0d want 0 0 0", act_wr_q.size(), act_rd_q.size(), miss_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = ram_init(12'(i));
        cyc = 0; miss_cnt = 0; req_cnt = 0;
        rst = 1'b1; vga_req = 1'b0; vga_addr = '0;
        cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        test_reset();
        test_cpu_write();
        test_vga_read();
        test_back_to_back();
        test_starvation();
        test_full_fifo();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
